// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl shared types: FSM states, forward selects, shadow slot.
// Imported by the comparator and the hazard_ctrl top.
package hazard_ctrl_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int SLOT_AW = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] dest;
    logic [SLOT_AW-1:0] src1;
    logic [SLOT_AW-1:0] src2;
    logic               two_src;
    logic               wb_en;
    logic               mem_read;
  } slot_t;

  localparam slot_t SLOT_NONE = '0;

  function automatic fwd_sel_t fwd_pick(
    input logic mem_hit,
    input logic wb_hit
  );
    unique case (1'b1)
      mem_hit: return FWD_MEM;
      wb_hit:  return FWD_WB;
      default: return FWD_REG;
    endcase
  endfunction

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// hazard_cmp: does a shadow slot write a given register.
// Register 0 never matches.
import hazard_ctrl_pkg::*;

module hazard_cmp (
  input  logic               valid,
  input  logic               wb_en,
  input  logic [SLOT_AW-1:0] dest,
  input  logic [SLOT_AW-1:0] r,
  output logic               hit
);

  assign hit = valid & wb_en
             & (dest == r)
             & (r != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/bubble and forwarding control
// for the 5-stage pipeline, with EXE/MEM/WB shadow slots.
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int REG_AW = SLOT_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forwarding_EN,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              branch_taken,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_exe_bubble,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] ONE = 1;

  slot_t  exe_q, mem_q, wb_q, id_s;
  state_t state_q;

  logic e1, e2, m1, m2;
  logic fm1, fm2, fw1, fw2;
  logic dep_e, dep_m;
  logic hazard, br, stall, fwd_on;
  logic unused;

  assign id_s = '{
    valid:    id_valid,
    dest:     id_dest,
    src1:     id_src1,
    src2:     id_src2,
    two_src:  id_two_src,
    wb_en:    id_wb_en,
    mem_read: id_mem_read
  };

  hazard_cmp u_e1 (.valid(exe_q.valid), .wb_en(exe_q.wb_en),
    .dest(exe_q.dest), .r(id_src1), .hit(e1));
  hazard_cmp u_e2 (.valid(exe_q.valid), .wb_en(exe_q.wb_en),
    .dest(exe_q.dest), .r(id_src2), .hit(e2));
  hazard_cmp u_m1 (.valid(mem_q.valid), .wb_en(mem_q.wb_en),
    .dest(mem_q.dest), .r(id_src1), .hit(m1));
  hazard_cmp u_m2 (.valid(mem_q.valid), .wb_en(mem_q.wb_en),
    .dest(mem_q.dest), .r(id_src2), .hit(m2));

  hazard_cmp u_fm1 (.valid(mem_q.valid), .wb_en(mem_q.wb_en),
    .dest(mem_q.dest), .r(exe_q.src1), .hit(fm1));
  hazard_cmp u_fm2 (.valid(mem_q.valid), .wb_en(mem_q.wb_en),
    .dest(mem_q.dest), .r(exe_q.src2), .hit(fm2));
  hazard_cmp u_fw1 (.valid(wb_q.valid), .wb_en(wb_q.wb_en),
    .dest(wb_q.dest), .r(exe_q.src1), .hit(fw1));
  hazard_cmp u_fw2 (.valid(wb_q.valid), .wb_en(wb_q.wb_en),
    .dest(wb_q.dest), .r(exe_q.src2), .hit(fw2));

  assign dep_e = e1 | (e2 & id_two_src);
  assign dep_m = m1 | (m2 & id_two_src);

  // WB writes are visible to ID reads, so WB never stalls
  assign hazard = rst & id_valid
                & (forwarding_EN ? (exe_q.mem_read & dep_e)
                                 : (dep_e | dep_m));

  assign br    = rst & branch_taken;
  assign stall = hazard & ~br;

  assign pc_hold       = stall;
  assign if_id_hold    = stall;
  assign if_id_flush   = br;
  assign id_exe_bubble = stall | br;

  assign fwd_on   = rst & forwarding_EN & exe_q.valid;
  assign fwd_sel1 = fwd_on ? fwd_pick(fm1, fw1) : FWD_REG;
  assign fwd_sel2 = (fwd_on & exe_q.two_src)
                  ? fwd_pick(fm2, fw2) : FWD_REG;

  assign state_o = state_q;

  assign unused = ^{mem_q.src1, mem_q.src2,
                    mem_q.two_src, mem_q.mem_read,
                    wb_q.src1, wb_q.src2,
                    wb_q.two_src, wb_q.mem_read};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q     <= SLOT_NONE;
      mem_q     <= SLOT_NONE;
      wb_q      <= SLOT_NONE;
      state_q   <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      exe_q <= id_exe_bubble ? SLOT_NONE : id_s;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + ONE;
      if (br && flush_cnt != '1)
        flush_cnt <= flush_cnt + ONE;
      unique case (state_q)
        RUN: begin
          if (br)         state_q <= FLUSH;
          else if (stall) state_q <= STALL;
        end
        STALL: begin
          if (br)          state_q <= FLUSH;
          else if (!stall) state_q <= RUN;
        end
        FLUSH: begin
          if (br)         state_q <= FLUSH;
          else if (stall) state_q <= STALL;
          else            state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors, instruction-level model,
// per-cycle compare plus hand-computed spot checks.
module tb_hazard_ctrl;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fwd_en = 1'b0;
  logic idv = 1'b0, two = 1'b0, wb = 1'b0, mr = 1'b0, br = 1'b0;
  logic [4:0] s1 = '0, s2 = '0, d = '0;
  logic pc_hold, if_id_hold, if_id_flush, id_exe_bubble;
  logic [1:0] fwd_sel1, fwd_sel2, state_o;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;
  bit fwd_next = 1'b0;

  hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .forwarding_EN(fwd_en),
    .id_valid(idv), .id_src1(s1), .id_src2(s2),
    .id_two_src(two), .id_dest(d), .id_wb_en(wb),
    .id_mem_read(mr), .branch_taken(br),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .if_id_flush(if_id_flush), .id_exe_bubble(id_exe_bubble),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .state_o(state_o), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int d; int a; int b; bit t; bit w; bit m;
  } rec_t;

  rec_t m_exe, m_mem, m_wb;
  int   m_state, m_sc, m_fc;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               n, $time, act, exp);
    end
  endtask

  function automatic bit wr(input rec_t x, input int r);
    return x.v && x.w && x.d == r && r != 0;
  endfunction

  function automatic bit m_hz();
    bit de, dm;
    de = wr(m_exe, s1) || (two && wr(m_exe, s2));
    dm = wr(m_mem, s1) || (two && wr(m_mem, s2));
    if (!idv) return 1'b0;
    return fwd_en ? (m_exe.m && de) : (de || dm);
  endfunction

  function automatic int m_sel(input int r);
    if (wr(m_mem, r)) return 1;
    if (wr(m_wb, r))  return 2;
    return 0;
  endfunction

  function automatic rec_t none();
    rec_t z;
    z = '{0, 0, 0, 0, 0, 0, 0};
    return z;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit st;
    if (!rst) begin
      m_exe <= none(); m_mem <= none(); m_wb <= none();
      m_state <= 0; m_sc <= 0; m_fc <= 0;
    end else begin
      st = m_hz() && !br;
      m_wb  <= m_mem;
      m_mem <= m_exe;
      if (st || br) m_exe <= none();
      else m_exe <= '{idv, d, s1, s2, two, wb, mr};
      m_state <= br ? 2 : (st ? 1 : 0);
      if (st && m_sc < SAT) m_sc <= m_sc + 1;
      if (br && m_fc < SAT) m_fc <= m_fc + 1;
    end
  end

  always @(negedge clk) begin
    bit st;
    if (!rst) begin
      chk("rst_outs", {pc_hold, if_id_hold, if_id_flush,
          id_exe_bubble, fwd_sel1, fwd_sel2, state_o}, 0);
      chk("rst_cnts", {stall_cnt, flush_cnt}, 0);
    end else begin
      st = m_hz() && !br;
      chk("pc_hold", pc_hold, st);
      chk("if_id_hold", if_id_hold, st);
      chk("if_id_flush", if_id_flush, br);
      chk("id_exe_bubble", id_exe_bubble, st || br);
      chk("state_o", state_o, m_state);
      chk("stall_cnt", stall_cnt, m_sc);
      chk("flush_cnt", flush_cnt, m_fc);
      if (m_exe.v) begin
        chk("fwd_sel1", fwd_sel1, fwd_en ? m_sel(m_exe.a) : 0);
        chk("fwd_sel2", fwd_sel2,
            (fwd_en && m_exe.t) ? m_sel(m_exe.b) : 0);
      end
    end
  end

  task automatic drive(input bit v, input int a, input int b,
                       input bit t, input int dd, input bit w,
                       input bit m, input bit bb);
    idv = v; s1 = 5'(a); s2 = 5'(b); two = t;
    d = 5'(dd); wb = w; mr = m; br = bb;
    fwd_en = fwd_next;
  endtask

  task automatic op(input bit v, input int a, input int b,
                    input bit t, input int dd, input bit w,
                    input bit m, input bit bb);
    @(posedge clk); #1;
    drive(v, a, b, t, dd, w, m, bb);
    @(negedge clk); #1;
  endtask

  task automatic nop();
    op(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input bit f);
    @(posedge clk); #1;
    rst = 1'b0;
    fwd_next = f;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    // load-use with forwarding
    do_reset(1);
    op(1, 1, 0, 0, 3, 1, 1, 0);
    chk("lu_pre", pc_hold, 0);
    op(1, 3, 5, 1, 4, 1, 0, 0);
    chk("lu_stall", pc_hold, 1);
    op(1, 3, 5, 1, 4, 1, 0, 0);
    chk("lu_release", pc_hold, 0);
    chk("lu_state", state_o, 1);
    chk("lu_scnt", stall_cnt, 1);
    nop();
    chk("lu_fwd1", fwd_sel1, 2);
    chk("lu_fwd2", fwd_sel2, 0);

    // stall-only mode, two stall cycles
    do_reset(0);
    op(1, 1, 1, 1, 2, 1, 0, 0);
    op(1, 2, 7, 1, 6, 1, 0, 0);
    chk("so_st1", pc_hold, 1);
    op(1, 2, 7, 1, 6, 1, 0, 0);
    chk("so_st2", pc_hold, 1);
    chk("so_state1", state_o, 1);
    op(1, 2, 7, 1, 6, 1, 0, 0);
    chk("so_st3", pc_hold, 0);
    chk("so_scnt", stall_cnt, 2);
    nop();
    chk("so_state2", state_o, 0);

    // MEM beats WB for forwarding
    do_reset(1);
    op(1, 1, 1, 1, 2, 1, 0, 0);
    op(1, 3, 3, 1, 2, 1, 0, 0);
    op(1, 2, 2, 1, 8, 1, 0, 0);
    chk("pr_nostall", pc_hold, 0);
    nop();
    chk("pr_fwd1", fwd_sel1, 1);
    chk("pr_fwd2", fwd_sel2, 1);

    // r0 never hazards or forwards
    for (int f = 0; f < 2; f++) begin
      do_reset(f[0]);
      op(1, 1, 1, 1, 0, 1, 1, 0);
      op(1, 0, 0, 1, 9, 1, 0, 0);
      chk("r0_stall", pc_hold, 0);
      nop();
      chk("r0_fwd", {fwd_sel1, fwd_sel2}, 0);
    end

    // branch beats load-use stall
    do_reset(1);
    op(1, 1, 0, 0, 3, 1, 1, 0);
    op(1, 3, 5, 1, 4, 1, 0, 1);
    chk("bs_hold", pc_hold, 0);
    chk("bs_flush", if_id_flush, 1);
    chk("bs_bubble", id_exe_bubble, 1);
    nop();
    chk("bs_state", state_o, 2);
    chk("bs_fcnt", flush_cnt, 1);
    chk("bs_scnt", stall_cnt, 0);

    // async reset during second stall cycle
    do_reset(0);
    op(1, 1, 1, 1, 2, 1, 0, 0);
    op(1, 2, 7, 1, 6, 1, 0, 0);
    op(1, 2, 7, 1, 6, 1, 0, 0);
    chk("ar_pre", pc_hold, 1);
    #1 rst = 1'b0;
    #1;
    chk("ar_hold", pc_hold, 0);
    chk("ar_bubble", id_exe_bubble, 0);
    chk("ar_state", state_o, 0);
    chk("ar_scnt", stall_cnt, 0);
    @(posedge clk); #2 rst = 1'b1;
    op(1, 2, 7, 1, 6, 1, 0, 0);
    chk("ar_clean", pc_hold, 0);
    chk("ar_state2", state_o, 0);

    // mode switch takes effect the same cycle
    do_reset(0);
    op(1, 1, 1, 1, 2, 1, 0, 0);
    fwd_next = 1'b1;
    op(1, 2, 2, 1, 6, 1, 0, 0);
    chk("ms_nostall", pc_hold, 0);
    fwd_next = 1'b0;
    nop();

    // counter saturation
    do_reset(0);
    for (int i = 0; i < 9; i++) begin
      op(1, 1, 1, 1, 2, 1, 0, 0);
      op(1, 2, 4, 0, 5, 1, 0, 0);
      op(1, 2, 4, 0, 5, 1, 0, 0);
    end
    nop();
    chk("sat_scnt", stall_cnt, SAT);
    for (int i = 0; i < 18; i++)
      op(1, 3, 3, 1, 4, 1, 0, 1);
    nop();
    chk("sat_fcnt", flush_cnt, SAT);
    nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline (IF, ID, EXE, MEM, WB).
- Shadows the destination and source registers of the instructions in EXE, MEM and WB.
- Generates stall, bubble and flush controls for the PC, IF2ID and ID2EXE registers.
- When forwarding_EN is high, also generates the EXE-stage operand forwarding selects.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- forwarding_EN  input  1  1 = forwarding mode, 0 = stall-only mode.
- id_valid  input  1  a real instruction sits in the ID stage.
- id_src1  input  REG_AW  ID-stage source register 1.
- id_src2  input  REG_AW  ID-stage source register 2.
- id_two_src  input  1  id_src2 is actually read (R-type or store).
- id_dest  input  REG_AW  ID-stage destination register.
- id_wb_en  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- branch_taken  input  1  branch resolved taken in EXE this cycle.
- pc_hold  output  1  freeze the PC.
- if_id_hold  output  1  freeze IF2IDReg.
- if_id_flush  output  1  clear IF2IDReg.
- id_exe_bubble  output  1  load a NOP into ID2EXEReg.
- fwd_sel1  output  2  EXE operand 1 source: 00 = regfile, 01 = EXE2MEM ALURes, 10 = WB value.
- fwd_sel2  output  2  same encoding, for operand 2 and ST_value.
- state_o  output  2  FSM state, for debug.
- stall_cnt  output  CNT_W  saturating count of stall cycles.
- flush_cnt  output  CNT_W  saturating count of flushes.

Behaviour:
- Shadow slots EXE, MEM and WB. Each slot holds {valid, dest, src1, src2, two_src, wb_en, mem_read}.
- Every posedge: WB <= MEM; MEM <= EXE; EXE <= bubble ? invalid : ID fields (valid = id_valid).
- A slot "writes r" when valid & wb_en & dest == r & r != 0. Register 0 never hazards and is never forwarded.
- Register-file writes in WB are visible to an ID read in the same cycle, so the WB slot never causes a stall.
- Hazard, forwarding_EN = 1 (load-use): EXE slot is a load (mem_read) and writes id_src1, or writes id_src2 while id_two_src. Always exactly 1 stall cycle.
- Hazard, forwarding_EN = 0: EXE or MEM slot writes id_src1, or writes id_src2 while id_two_src. Up to 2 stall cycles.
- Hazard is only evaluated when id_valid = 1.
- Outputs are combinational (Mealy):
  - stall = hazard & ~branch_taken.
  - pc_hold = if_id_hold = stall.
  - id_exe_bubble = stall | branch_taken.
  - if_id_flush = branch_taken.
- branch_taken has priority over stall: no hold, flush IF2ID, bubble ID2EXE.
- Forwarding applies to the EXE-slot operands, only when forwarding_EN = 1; otherwise 00.
  - fwd_selN = 01 if the MEM slot writes the EXE srcN.
  - else 10 if the WB slot writes the EXE srcN.
  - else 00. MEM takes priority over WB.
  - fwd_sel2 applies only if the EXE slot has two_src; otherwise 00.
- FSM states: RUN = 0, STALL = 1, FLUSH = 2.
  - RUN -> STALL on stall; RUN -> FLUSH on branch_taken.
  - STALL -> STALL while stall persists; STALL -> FLUSH on branch_taken; otherwise STALL -> RUN.
  - FLUSH -> FLUSH on branch_taken; FLUSH -> STALL on stall; otherwise FLUSH -> RUN.
- stall_cnt increments each cycle stall = 1. flush_cnt increments each cycle branch_taken = 1. Both saturate at all-ones and never wrap.
- Reset (rst = 0), any time including mid-stall:
  - all slots invalid, state RUN, counters 0.
  - all outputs 0 immediately and asynchronously: outputs are qualified by rst, not only through the flops.
- Changing forwarding_EN mid-run takes effect on the same cycle's hazard and forwarding evaluation.

Decomposition:
- In the defines package: state_t enum {RUN, STALL, FLUSH}; fwd_sel_t enum {FWD_REG = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10}; slot_t packed struct for the shadow slot; HIGH/LOW reused.
- One sub-module: hazard_cmp, combinational "slot writes register" comparator, instantiated per slot/operand pair.

Test Plan:
- forwarding_EN = 1: LW r3 followed by ADD r4, r3, r5 -> stall/pc_hold = 1 for exactly 1 cycle. On the next cycle EXE ADD gets fwd_sel1 = 10; stall_cnt = 1.
- forwarding_EN = 0: ADD r2, r1, r1 then SUB r6, r2, r7 -> 2 consecutive stall cycles, state_o STALL then RUN; stall_cnt = 2.
- forwarding_EN = 1: ADD r2 then ADD r2 then OR r8, r2, r2 -> no stall. OR in EXE sees fwd_sel1 = fwd_sel2 = 01 (MEM priority over WB).
- Dest r0 writer followed by a reader of r0, both modes -> no stall, fwd_sel = 00.
- Load-use hazard and branch_taken in the same cycle -> pc_hold = 0, if_id_flush = 1, id_exe_bubble = 1, state_o = FLUSH; flush_cnt = 1, stall_cnt unchanged.
- rst driven 0 mid-stall (forwarding_EN = 0, second stall cycle) -> all outputs 0 asynchronously. After release: state RUN, counters 0, no stale hazard from old slots.
